core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_seq_pkg.sv | 37 +++
 rtl/core_sequencer.sv | 133 +++++++++++++
 tb/tb_core_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_pkg.sv
// Shared types and constants for the attention-core sequencer: the state set
// and the bit layout of the 19-bit core instruction word.
package core_seq_pkg;

    localparam int INST_W       = 19;
    localparam int ADDR_FIELD_W = 4;

    localparam int SFP_DIV_BIT   = 18;
    localparam int SFP_ACC_BIT   = 17;
    localparam int OFIFO_RD_BIT  = 16;
    localparam int QKMEM_ADD_MSB = 15;
    localparam int QKMEM_ADD_LSB = 12;
    localparam int PMEM_ADD_MSB  = 11;
    localparam int PMEM_ADD_LSB  = 8;
    localparam int EXECUTE_BIT   = 7;
    localparam int KLOAD_BIT     = 6;
    localparam int QMEM_RD_BIT   = 5;
    localparam int QMEM_WR_BIT   = 4;
    localparam int KMEM_RD_BIT   = 3;
    localparam int KMEM_WR_BIT   = 2;
    localparam int PMEM_RD_BIT   = 1;
    localparam int PMEM_WR_BIT   = 0;

    typedef enum logic [3:0] {
        IDLE,
        LD_Q,
        LD_K,
        KLOAD,
        KDRAIN,
        EXEC,
        ACC,
        DIV,
        RD_OUT,
        DONE
    } state_e;

endpackage

// File: rtl/core_sequencer.sv
// Tile sequencer: walks one Q/K tile through load, kernel load, drain, execute,
// accumulate, divide and read-out, emitting the core instruction word each cycle.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int ADDR_W = 4,
    parameter int DRAIN  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              fifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] ROWS_LAST  = CW'(ROWS - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    out_valid_q;
    logic [CW-1:0]           cnt_inc;
    logic                    rows_last;
    logic [ADDR_FIELD_W-1:0] addr;

    assign cnt_inc   = cnt_q + 1'b1;
    assign rows_last = (cnt_q == ROWS_LAST);
    assign addr      = ADDR_FIELD_W'(cnt_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= inst[PMEM_RD_BIT];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inst     = '0;
        in_ready = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LD_Q;
                    cnt_d   = '0;
                end
            end
            LD_Q, LD_K: begin
                // Only accepted rows advance the address; idle host cycles hold it.
                in_ready = 1'b1;
                if (in_valid) begin
                    inst[QKMEM_ADD_MSB:QKMEM_ADD_LSB] = addr;
                    if (state_q == LD_Q) inst[QMEM_WR_BIT] = 1'b1;
                    else                 inst[KMEM_WR_BIT] = 1'b1;
                    cnt_d = rows_last ? '0 : cnt_inc;
                    if (rows_last) state_d = (state_q == LD_Q) ? LD_K : KLOAD;
                end
            end
            KLOAD: begin
                inst[KLOAD_BIT]                   = 1'b1;
                inst[KMEM_RD_BIT]                 = 1'b1;
                inst[QKMEM_ADD_MSB:QKMEM_ADD_LSB] = addr;
                cnt_d = rows_last ? '0 : cnt_inc;
                if (rows_last) state_d = KDRAIN;
            end
            KDRAIN: begin
                cnt_d = (cnt_q == DRAIN_LAST) ? '0 : cnt_inc;
                if (cnt_q == DRAIN_LAST) state_d = EXEC;
            end
            EXEC: begin
                inst[EXECUTE_BIT]                 = 1'b1;
                inst[QMEM_RD_BIT]                 = 1'b1;
                inst[QKMEM_ADD_MSB:QKMEM_ADD_LSB] = addr;
                cnt_d = rows_last ? '0 : cnt_inc;
                if (rows_last) state_d = ACC;
            end
            ACC: begin
                if (fifo_valid) begin
                    inst[OFIFO_RD_BIT] = 1'b1;
                    inst[SFP_ACC_BIT]  = 1'b1;
                    cnt_d = rows_last ? '0 : cnt_inc;
                    if (rows_last) state_d = DIV;
                end
            end
            DIV: begin
                inst[SFP_DIV_BIT]               = 1'b1;
                inst[PMEM_WR_BIT]               = 1'b1;
                inst[PMEM_ADD_MSB:PMEM_ADD_LSB] = addr;
                cnt_d = rows_last ? '0 : cnt_inc;
                if (rows_last) state_d = RD_OUT;
            end
            RD_OUT: begin
                inst[PMEM_RD_BIT]               = 1'b1;
                inst[PMEM_ADD_MSB:PMEM_ADD_LSB] = addr;
                cnt_d = rows_last ? '0 : cnt_inc;
                if (rows_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Abort overrides every transition but leaves this cycle's decode intact.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: a flattened per-tile instruction program acts as
// the reference; every cycle the DUT outputs are compared with it.
module tb_core_sequencer;

    localparam int B_SFP_DIV  = 18;
    localparam int B_SFP_ACC  = 17;
    localparam int B_OFIFO_RD = 16;
    localparam int B_EXECUTE  = 7;
    localparam int B_KLOAD    = 6;
    localparam int B_QMEM_RD  = 5;
    localparam int B_QMEM_WR  = 4;
    localparam int B_KMEM_RD  = 3;
    localparam int B_KMEM_WR  = 2;
    localparam int B_PMEM_RD  = 1;
    localparam int B_PMEM_WR  = 0;

    logic        clk = 1'b0;
    logic        reset, start, abort, in_valid, fifo_valid;
    logic        in_ready, out_valid, busy, done;
    logic [18:0] inst;

    core_sequencer #(.ROWS(8), .ADDR_W(4), .DRAIN(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .fifo_valid(fifo_valid),
        .inst(inst), .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // reference: queue of expected instruction words, each gated on nothing (0),
    // in_valid (1) or fifo_valid (2); an empty queue while running means DONE
    logic [18:0] exp_q[$];
    int          gate_q[$];
    bit          m_run;
    logic        m_ov;
    int          n_vec, n_err;
    string       cur;
    logic [18:0] obs_inst;
    logic        obs_ov, obs_done, obs_busy, obs_rdy;

    function automatic logic [18:0] bitw(input int b);
        logic [18:0] w;
        w = '0;
        w[b] = 1'b1;
        return w;
    endfunction

    function automatic logic [18:0] qk(input int a);
        return 19'(a) << 12;
    endfunction

    function automatic logic [18:0] pa(input int a);
        return 19'(a) << 8;
    endfunction

    task automatic push(input logic [18:0] w, input int g);
        exp_q.push_back(w);
        gate_q.push_back(g);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 8; i++) push(bitw(B_QMEM_WR) | qk(i), 1);
        for (int i = 0; i < 8; i++) push(bitw(B_KMEM_WR) | qk(i), 1);
        for (int i = 0; i < 8; i++) push(bitw(B_KLOAD) | bitw(B_KMEM_RD) | qk(i), 0);
        for (int i = 0; i < 8; i++) push('0, 0);
        for (int i = 0; i < 8; i++) push(bitw(B_EXECUTE) | bitw(B_QMEM_RD) | qk(i), 0);
        for (int i = 0; i < 8; i++) push(bitw(B_OFIFO_RD) | bitw(B_SFP_ACC), 2);
        for (int i = 0; i < 8; i++) push(bitw(B_SFP_DIV) | bitw(B_PMEM_WR) | pa(i), 0);
        for (int i = 0; i < 8; i++) push(bitw(B_PMEM_RD) | pa(i), 0);
    endtask

    task automatic model_reset();
        m_run = 0;
        m_ov  = 1'b0;
        exp_q.delete();
        gate_q.delete();
    endtask

    function automatic logic [18:0] head();
        return (m_run && exp_q.size() > 0) ? exp_q[0] : '0;
    endfunction

    function automatic int head_gate();
        return (m_run && gate_q.size() > 0) ? gate_q[0] : -1;
    endfunction

    // driver + scoreboard: one clock cycle, called at posedge+1
    task automatic tick(input logic st, input logic ab, input logic iv, input logic fv);
        logic [18:0] e_inst;
        logic        e_rdy, e_busy, e_done;
        bit          consume;
        int          g;
        start = st; abort = ab; in_valid = iv; fifo_valid = fv;
        e_inst = '0; e_rdy = 1'b0; e_busy = m_run; e_done = 1'b0; consume = 0;
        if (m_run) begin
            if (exp_q.size() == 0) e_done = 1'b1;
            else begin
                g = gate_q[0];
                e_rdy = (g == 1);
                if (g == 0 || (g == 1 && iv) || (g == 2 && fv)) begin
                    e_inst  = exp_q[0];
                    consume = 1;
                end
            end
        end
        @(negedge clk);
        obs_inst = inst; obs_ov = out_valid; obs_done = done; obs_busy = busy; obs_rdy = in_ready;
        n_vec += 5;
        if (inst !== e_inst) begin
            n_err++; $display("FAIL %s/inst t=%0t got=%h want=%h", cur, $time, inst, e_inst);
        end
        if (in_ready !== e_rdy) begin
            n_err++; $display("FAIL %s/in_ready t=%0t got=%b want=%b", cur, $time, in_ready, e_rdy);
        end
        if (busy !== e_busy) begin
            n_err++; $display("FAIL %s/busy t=%0t got=%b want=%b", cur, $time, busy, e_busy);
        end
        if (done !== e_done) begin
            n_err++; $display("FAIL %s/done t=%0t got=%b want=%b", cur, $time, done, e_done);
        end
        if (out_valid !== m_ov) begin
            n_err++; $display("FAIL %s/out_valid t=%0t got=%b want=%b", cur, $time, out_valid, m_ov);
        end
        @(posedge clk);
        m_ov = e_inst[B_PMEM_RD];
        if (m_run && ab) begin
            m_run = 0; exp_q.delete(); gate_q.delete();
        end else if (!m_run) begin
            if (st) begin m_run = 1; load_prog(); end
        end else if (exp_q.size() == 0) m_run = 0;
        else if (consume) begin
            void'(exp_q.pop_front());
            void'(gate_q.pop_front());
        end
        #1;
    endtask

    task automatic run_to_idle(input int max_cyc);
        int n;
        n = 0;
        while (m_run && n < max_cyc) begin
            tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n++;
        end
        n_vec++;
        if (m_run) begin
            n_err++; $display("FAIL %s/timeout got=running want=idle", cur);
            model_reset();
            reset = 1'b0; #1; reset = 1'b1;
        end
    endtask

    task automatic test_reset();
        cur = "reset";
        reset = 1'b0; start = 1'b1; abort = 1'b0; in_valid = 1'b1; fifo_valid = 1'b1;
        model_reset();
        #1;
        n_vec += 5;
        if (inst !== 19'd0)   begin n_err++; $display("FAIL reset/inst got=%h want=0", inst); end
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset/in_ready got=%b want=0", in_ready); end
        if (busy !== 1'b0)    begin n_err++; $display("FAIL reset/busy got=%b want=0", busy); end
        if (done !== 1'b0)    begin n_err++; $display("FAIL reset/done got=%b want=0", done); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset/out_valid got=%b want=0", out_valid); end
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset/busy_held got=%b want=0", busy); end
        reset = 1'b1;
        tick(1'b1, 1'b0, 1'b1, 1'b1);   // start on the first edge after release
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);   // abort during LD_Q
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_nominal();
        int cyc, done_cyc, qwr, kwr, kl, dv, ov, ex;
        cur = "nominal";
        cyc = 0; done_cyc = -1; qwr = 0; kwr = 0; kl = 0; dv = 0; ov = 0; ex = 0;
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        while (m_run && cyc < 200) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1);
            cyc++;
            if (obs_done) done_cyc = cyc;
            if (obs_inst[B_QMEM_WR]) qwr++;
            if (obs_inst[B_KMEM_WR]) kwr++;
            if (obs_inst[B_KLOAD]) kl++;
            if (obs_inst[B_EXECUTE]) ex++;
            if (obs_inst[B_PMEM_WR]) dv++;
            if (obs_ov) ov++;
        end
        n_vec += 7;
        if (done_cyc !== 65) begin n_err++; $display("FAIL nominal/done_cycle got=%0d want=65", done_cyc); end
        if (qwr !== 8) begin n_err++; $display("FAIL nominal/qmem_wr got=%0d want=8", qwr); end
        if (kwr !== 8) begin n_err++; $display("FAIL nominal/kmem_wr got=%0d want=8", kwr); end
        if (kl !== 8)  begin n_err++; $display("FAIL nominal/kload got=%0d want=8", kl); end
        if (ex !== 8)  begin n_err++; $display("FAIL nominal/exec got=%0d want=8", ex); end
        if (dv !== 8)  begin n_err++; $display("FAIL nominal/pmem_wr got=%0d want=8", dv); end
        if (ov !== 8)  begin n_err++; $display("FAIL nominal/out_valid got=%0d want=8", ov); end
    endtask

    task automatic test_backpressure();
        int c, addrs[$];
        cur = "backpressure";
        c = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        while (m_run && c < 300) begin
            tick(1'b0, 1'b0, (c < 16) ? 1'(c % 2 == 0) : 1'b1, 1'($urandom_range(0, 1)));
            if (obs_inst[B_QMEM_WR]) addrs.push_back(int'(obs_inst[15:12]));
            c++;
        end
        n_vec++;
        if (addrs.size() !== 8) begin n_err++; $display("FAIL backpressure/count got=%0d want=8", addrs.size()); end
        for (int i = 0; i < addrs.size(); i++) begin
            n_vec++;
            if (addrs[i] !== i) begin n_err++; $display("FAIL backpressure/addr%0d got=%0d want=%0d", i, addrs[i], i); end
        end
    endtask

    task automatic test_fifo_stall();
        int c, reads, stall, gap, divs;
        logic fv, prev_div;
        cur = "fifo_stall";
        c = 0; reads = 0; stall = 0; gap = 0; divs = 0; prev_div = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        while (m_run && c < 300) begin
            fv = 1'b1;
            if (head_gate() == 2 && reads == 3 && stall < 5) begin fv = 1'b0; stall++; end
            tick(1'b0, 1'b0, 1'b1, fv);
            if (obs_inst[B_OFIFO_RD]) reads++;
            else if (reads == 3 && obs_inst == 19'd0) gap++;
            if (obs_inst[B_SFP_DIV] && !prev_div) divs++;
            prev_div = obs_inst[B_SFP_DIV];
            c++;
        end
        n_vec += 3;
        if (reads !== 8) begin n_err++; $display("FAIL fifo_stall/reads got=%0d want=8", reads); end
        if (gap !== 5)   begin n_err++; $display("FAIL fifo_stall/stall_cycles got=%0d want=5", gap); end
        if (divs !== 1)  begin n_err++; $display("FAIL fifo_stall/div_entries got=%0d want=1", divs); end
    endtask

    task automatic test_abort();
        int c;
        logic [18:0] target;
        cur = "abort";
        target = bitw(B_EXECUTE) | bitw(B_QMEM_RD) | qk(4);
        c = 0;
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        while (m_run && head() != target && c < 300) begin
            tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
            c++;
        end
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        n_vec += 2;
        if (obs_inst !== 19'd0) begin n_err++; $display("FAIL abort/inst_after got=%h want=0", obs_inst); end
        if (obs_busy !== 1'b0)  begin n_err++; $display("FAIL abort/busy_after got=%b want=0", obs_busy); end
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (obs_inst !== bitw(B_QMEM_WR)) begin
            n_err++; $display("FAIL abort/restart got=%h want=%h", obs_inst, bitw(B_QMEM_WR));
        end
        run_to_idle(400);
    endtask

    task automatic test_async_reset();
        int c;
        cur = "async_reset";
        c = 0;
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        while (m_run && !(head() & bitw(B_SFP_DIV)) && c < 300) begin
            tick(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
            c++;
        end
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        #2 reset = 1'b0;
        #1;
        n_vec += 3;
        if (inst !== 19'd0)    begin n_err++; $display("FAIL async_reset/inst got=%h want=0", inst); end
        if (busy !== 1'b0)     begin n_err++; $display("FAIL async_reset/busy got=%b want=0", busy); end
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL async_reset/in_ready got=%b want=0", in_ready); end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_start_held();
        int c, idle_seen;
        cur = "start_held";
        c = 0; idle_seen = 0;
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        while (m_run && c < 400) begin
            tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (!obs_busy) idle_seen++;
            c++;
        end
        n_vec++;
        if (idle_seen !== 0) begin n_err++; $display("FAIL start_held/idle_while_run got=%0d want=0", idle_seen); end
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (obs_busy !== 1'b0) begin n_err++; $display("FAIL start_held/idle_gap got=%b want=0", obs_busy); end
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (obs_busy !== 1'b1) begin n_err++; $display("FAIL start_held/restart got=%b want=1", obs_busy); end
        run_to_idle(400);
    endtask

    task automatic test_random();
        cur = "random";
        for (int t = 0; t < 6; t++) begin
            int c;
            c = 0;
            tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            while (m_run && c < 400) begin
                tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
                c++;
            end
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_fifo_stall();
        test_abort();
        test_async_reset();
        test_start_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
